// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage access controller.
// The slave modport is the controller; the master modport is pipeline plus memory.
interface mem_access_ctrl_if;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        dmem_en;
    logic        dmem_wr;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ready;
    logic [15:0] dmem_rdata;
    logic [15:0] rdata_out;
    logic        stall;
    logic        mem_err;

    modport slave (
        input  mem_read_in, mem_write_in, addr_in, wdata_in, dmem_ready, dmem_rdata,
        output dmem_en, dmem_wr, dmem_addr, dmem_wdata, rdata_out, stall, mem_err
    );

    modport master (
        output mem_read_in, mem_write_in, addr_in, wdata_in, dmem_ready, dmem_rdata,
        input  dmem_en, dmem_wr, dmem_addr, dmem_wdata, rdata_out, stall, mem_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: request/ready handshake with timeout, stalls the
// pipeline for the whole access and releases it for one DONE cycle with the load result.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_access_ctrl_if.slave         bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        stall_raw;
    logic        req;

    assign req = bus.mem_read_in | bus.mem_write_in;

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    stall_raw = 1'b1;
                    state_d   = StBusy;
                    en_d      = 1'b1;
                    // Both op bits set resolves to a write.
                    wr_d      = bus.mem_write_in;
                    addr_d    = bus.addr_in;
                    wdata_d   = bus.wdata_in;
                    cnt_d     = 8'd0;
                end
            end
            StBusy: begin
                stall_raw = 1'b1;
                // A ready arriving on the timeout edge still counts as a normal completion.
                if (bus.dmem_ready) begin
                    en_d    = 1'b0;
                    state_d = StDone;
                    if (!wr_q) rdata_d = bus.dmem_rdata;
                end else if (cnt_q == CntLast) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = StDone;
                    if (!wr_q) rdata_d = 16'hFFFF;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset masks the combinational stall so a held op cannot freeze the pipeline in reset.
    assign bus.stall      = rst_n & stall_raw;
    assign bus.dmem_en    = en_q;
    assign bus.dmem_wr    = wr_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.rdata_out  = rdata_q;
    assign bus.mem_err    = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed test-plan scenarios plus randomized
// accesses checked against a transaction-level model of stall/handshake/result behaviour.
module tb_mem_access_ctrl;

    localparam int unsigned TimeoutCyc = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT(TimeoutCyc)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] exp_rdata = 16'h0000;
    logic        exp_err = 1'b0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] d);
        bus.mem_read_in  = rd;
        bus.mem_write_in = wr;
        bus.addr_in      = a;
        bus.wdata_in     = d;
    endtask

    // One complete access starting in IDLE; k = cycle of ready (0 or > TimeoutCyc: none).
    task automatic run_access(input string name, input logic rd, input logic wr,
                              input logic [15:0] a, input logic [15:0] d, input int k,
                              input logic [15:0] rdat);
        bit   hit;
        int   last;
        logic is_wr;
        is_wr = wr;
        hit   = (k >= 1) && (k <= int'(TimeoutCyc));
        last  = hit ? k : int'(TimeoutCyc);

        next_cycle();
        drive_ops(rd, wr, a, d);
        bus.dmem_ready = 1'($urandom_range(0, 1));
        bus.dmem_rdata = 16'($urandom);
        #1;
        n_cmp++;
        if ({bus.stall, bus.dmem_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s req: stall/en got %b%b want 10", name, bus.stall, bus.dmem_en);
        end

        for (int c = 1; c <= last; c++) begin
            next_cycle();
            bus.dmem_ready = (c == k);
            bus.dmem_rdata = (c == k) ? rdat : 16'($urandom);
            #1;
            n_cmp++;
            if ({bus.stall, bus.dmem_en, bus.dmem_wr, bus.dmem_addr, bus.dmem_wdata}
                !== {1'b1, 1'b1, is_wr, a, d}) begin
                n_fail++;
                $display("FAIL %s busy c%0d: stall=%b en=%b wr=%b addr=%h wdata=%h want 1 1 %b %h %h",
                         name, c, bus.stall, bus.dmem_en, bus.dmem_wr, bus.dmem_addr,
                         bus.dmem_wdata, is_wr, a, d);
            end
        end

        if (hit) begin
            if (!is_wr) exp_rdata = rdat;
        end else begin
            exp_err = 1'b1;
            if (!is_wr) exp_rdata = 16'hFFFF;
        end

        // DONE: op inputs still hold the finished instruction; ready is noise.
        next_cycle();
        bus.dmem_ready = 1'($urandom_range(0, 1));
        bus.dmem_rdata = 16'($urandom);
        #1;
        n_cmp++;
        if ({bus.stall, bus.dmem_en, bus.rdata_out, bus.mem_err}
            !== {1'b0, 1'b0, exp_rdata, exp_err}) begin
            n_fail++;
            $display("FAIL %s done: stall=%b en=%b rdata=%h err=%b want 0 0 %h %b",
                     name, bus.stall, bus.dmem_en, bus.rdata_out, bus.mem_err,
                     exp_rdata, exp_err);
        end
    endtask

    task automatic idle_cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            drive_ops(1'b0, 1'b0, 16'($urandom), 16'($urandom));
            bus.dmem_ready = 1'($urandom_range(0, 1));
            bus.dmem_rdata = 16'($urandom);
            #1;
            n_cmp++;
            if ({bus.stall, bus.dmem_en, bus.rdata_out, bus.mem_err}
                !== {1'b0, 1'b0, exp_rdata, exp_err}) begin
                n_fail++;
                $display("FAIL %s idle: stall=%b en=%b rdata=%h err=%b want 0 0 %h %b",
                         name, bus.stall, bus.dmem_en, bus.rdata_out, bus.mem_err,
                         exp_rdata, exp_err);
            end
        end
    endtask

    task automatic test_reset();
        drive_ops(1'b1, 1'b0, 16'h5555, 16'hAAAA);
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 16'h1111;
        #3;
        n_cmp++;
        if ({bus.stall, bus.dmem_en, bus.dmem_wr, bus.dmem_addr, bus.dmem_wdata,
             bus.rdata_out, bus.mem_err} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset: stall=%b en=%b wr=%b addr=%h wdata=%h rdata=%h err=%b want all 0",
                     bus.stall, bus.dmem_en, bus.dmem_wr, bus.dmem_addr, bus.dmem_wdata,
                     bus.rdata_out, bus.mem_err);
        end
        next_cycle();
        drive_ops(1'b0, 1'b0, 16'h0000, 16'h0000);
        bus.dmem_ready = 1'b0;
        rst_n = 1'b1;
        exp_rdata = 16'h0000;
        exp_err   = 1'b0;
        idle_cycles("post_reset", 2);
    endtask

    task automatic test_load();
        run_access("load", 1'b1, 1'b0, 16'h0040, 16'h0000, 3, 16'hBEEF);
        n_cmp++;
        if (bus.rdata_out !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL load_result: rdata=%h want beef", bus.rdata_out);
        end
    endtask

    task automatic test_store();
        run_access("store", 1'b0, 1'b1, 16'h0010, 16'h1234, 1, 16'h9999);
        n_cmp++;
        if (bus.rdata_out !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL store_keeps_rdata: rdata=%h want beef", bus.rdata_out);
        end
        idle_cycles("store_gap", 1);
    endtask

    task automatic test_back_to_back();
        run_access("b2b_first", 1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'h0A0A);
        run_access("b2b_second", 1'b1, 1'b0, 16'h0102, 16'h0000, 1, 16'h0B0B);
        run_access("b2b_third", 1'b1, 1'b1, 16'h0104, 16'h7777, 2, 16'h0C0C);
        idle_cycles("b2b_gap", 2);
    endtask

    task automatic test_ready_at_timeout();
        run_access("ready_at_timeout", 1'b1, 1'b0, 16'h0200, 16'h0000, int'(TimeoutCyc),
                   16'hC0DE);
        n_cmp++;
        if (bus.mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_at_timeout_err: mem_err=%b want 0", bus.mem_err);
        end
        idle_cycles("rat_gap", 1);
    endtask

    task automatic test_timeout();
        run_access("timeout", 1'b1, 1'b0, 16'h0300, 16'h0000, 0, 16'h0000);
        n_cmp++;
        if ({bus.mem_err, bus.rdata_out} !== {1'b1, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL timeout_result: err=%b rdata=%h want 1 ffff", bus.mem_err,
                     bus.rdata_out);
        end
        run_access("sticky_load", 1'b1, 1'b0, 16'h0302, 16'h0000, 2, 16'h4321);
        run_access("sticky_store", 1'b0, 1'b1, 16'h0304, 16'h5678, 1, 16'h0000);
        run_access("timeout_store", 1'b0, 1'b1, 16'h0306, 16'h9ABC, 0, 16'h0000);
        idle_cycles("sticky_gap", 2);
    endtask

    task automatic test_reset_mid_busy();
        next_cycle();
        drive_ops(1'b1, 1'b0, 16'h0400, 16'h0000);
        bus.dmem_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.stall, bus.dmem_en, bus.dmem_wr, bus.dmem_addr, bus.dmem_wdata,
             bus.rdata_out, bus.mem_err} !== 51'd0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: stall=%b en=%b wr=%b addr=%h wdata=%h rdata=%h err=%b want all 0",
                     bus.stall, bus.dmem_en, bus.dmem_wr, bus.dmem_addr, bus.dmem_wdata,
                     bus.rdata_out, bus.mem_err);
        end
        exp_rdata = 16'h0000;
        exp_err   = 1'b0;
        next_cycle();
        drive_ops(1'b0, 1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            bus.dmem_ready = 1'b1;
            bus.dmem_rdata = 16'hABCD;
            #1;
            n_cmp++;
            if ({bus.stall, bus.dmem_en, bus.rdata_out, bus.mem_err} !== 18'd0) begin
                n_fail++;
                $display("FAIL late_ready_ignored: stall=%b en=%b rdata=%h err=%b want 0 0 0000 0",
                         bus.stall, bus.dmem_en, bus.rdata_out, bus.mem_err);
            end
        end
        bus.dmem_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(1, 3));
            idle_cycles("rand_gap", int'($urandom_range(0, 2)));
            run_access("rand", op[0], op[1], 16'($urandom), 16'($urandom),
                       int'($urandom_range(0, 6)), 16'($urandom));
        end
    endtask

    initial begin
        bus.mem_read_in  = 1'b0;
        bus.mem_write_in = 1'b0;
        bus.addr_in      = 16'h0000;
        bus.wdata_in     = 16'h0000;
        bus.dmem_ready   = 1'b0;
        bus.dmem_rdata   = 16'h0000;
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_ready_at_timeout();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences multi-cycle data-memory accesses for the MEM stage of the 16-bit five-stage pipeline. It samples the memory-op controls and operands held in the EX/MEM pipeline register, runs a request/ready handshake with the data memory, and drives a `stall` signal. `stall` freezes every upstream pipeline register (PC, IF/ID, ID/EX, EX/MEM) and makes MEM/WB capture a NOP. When the access completes, the block presents the load result to MEM/WB and releases the pipeline.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum BUSY cycles without `dmem_ready` before an error abort. Legal range 1–255.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_read_in` in 1: load in MEM stage, from EX/MEM.
- `mem_write_in` in 1: store in MEM stage, from EX/MEM.
- `addr_in` in 16: effective address (EX/MEM ALU result).
- `wdata_in` in 16: store data (EX/MEM data-in).
- `dmem_en` out 1: memory request, held high for the whole access.
- `dmem_wr` out 1: 1 = write, 0 = read. Valid while `dmem_en` is high.
- `dmem_addr` out 16: latched address.
- `dmem_wdata` out 16: latched store data.
- `dmem_ready` in 1: one-cycle completion strobe from memory.
- `dmem_rdata` in 16: read data, valid with `dmem_ready`.
- `rdata_out` out 16: registered load result to MEM/WB.
- `stall` out 1: combinational. Upstream pipeline register `wen` = `~stall`; MEM/WB inserts a NOP while high.
- `mem_err` out 1: sticky timeout flag.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE:** `req` = `mem_read_in | mem_write_in`.
  - With `req`: `stall` = 1 this cycle. At the next edge, latch `addr_in` and `wdata_in`, set `dmem_wr` = `mem_write_in`, set `dmem_en` = 1, clear `cnt`, and go to BUSY.
  - If both op bits are set, the access is a write.
  - Without `req`: `stall` = 0 and the state is unchanged.
- **BUSY:** `stall` = 1; `dmem_en`, `dmem_wr`, `dmem_addr` and `dmem_wdata` are held stable.
  - `dmem_ready` sampled high at an edge: clear `dmem_en`. If the access is a read, `rdata_out` ← `dmem_rdata`. Go to DONE.
  - Otherwise `cnt` increments. If `cnt` == `TIMEOUT`−1 at that edge: clear `dmem_en`, set `mem_err`, set `rdata_out` ← 16'hFFFF for a read (unchanged for a write), and go to DONE.
  - If `dmem_ready` and the timeout coincide, `dmem_ready` wins: normal completion, `mem_err` not set.
- **DONE:** `stall` = 0 for exactly one cycle, so the completed instruction advances into MEM/WB with `rdata_out`. Op inputs are ignored because they still belong to the finished instruction. Next state is IDLE unconditionally.
- `rdata_out` changes only on read completion or read timeout. Writes leave it unchanged.
- `dmem_ready` in IDLE or DONE is ignored.
- `mem_err` is cleared only by reset.
- Asserting `rst_n` low at any time, mid-BUSY included, immediately forces the following, without waiting for a clock edge:
  - state = IDLE
  - `dmem_en` = 0, `dmem_wr` = 0
  - `dmem_addr` = 0, `dmem_wdata` = 0
  - `rdata_out` = 0, `mem_err` = 0
  - `cnt` = 0
  
  An in-flight access is abandoned, and any later `dmem_ready` is ignored.

## Timing
- Reset values: every output is 0. `stall` is 0 while `rst_n` is low; it is combinational from state and inputs.
- Memory access timeline, with cycle 0 = IDLE with `req`:
  - `dmem_en` rises at the edge ending cycle 0.
  - If `dmem_ready` is high in cycle k (k ≥ 1), DONE is cycle k+1 and IDLE is cycle k+2.
  - Total stall cycles = k+1.
  - Minimum access is 3 cycles (k = 1): 2 stall cycles plus 1 DONE cycle.
- Back-to-back memory ops: the next instruction reaches EX/MEM at the edge ending DONE and is sampled in IDLE the following cycle. There is no extra gap.
- Timeout: with no `dmem_ready`, DONE occurs in cycle `TIMEOUT`+1, for `TIMEOUT`+1 stall cycles total.
- Non-memory instructions add zero latency.

## Test plan
- **Load:** `mem_read_in` = 1, `addr_in` = 16'h0040. Memory returns `dmem_ready` with 16'hBEEF in cycle 3. Required:
  - `dmem_en` high in cycles 1–3, with `dmem_addr` = 16'h0040 and `dmem_wr` = 0.
  - `stall` high in cycles 0–3.
  - `rdata_out` = 16'hBEEF in cycle 4 (DONE), with `stall` = 0.
- **Store:** `mem_write_in` = 1, `addr_in` = 16'h0010, `wdata_in` = 16'h1234, ready in cycle 1. Required:
  - `dmem_wr` = 1 and `dmem_wdata` = 16'h1234 in cycle 1.
  - DONE in cycle 2.
  - `rdata_out` keeps its prior value.
- **Back-to-back loads, ready at k = 1 each:** a second load enters EX/MEM at the edge after DONE. Required: its `dmem_en` rises two cycles after the first DONE, and there is one `stall`-low cycle between the two accesses.
- **Timeout, `TIMEOUT` = 4, no ready:** required:
  - `mem_err` = 1 and `rdata_out` = 16'hFFFF in DONE (cycle 5).
  - `mem_err` stays 1 through subsequent normal accesses.
- **Ready coincident with timeout, `TIMEOUT` = 4, ready in cycle 4:** required: normal completion and `mem_err` = 0.
- **Reset mid-BUSY:**
  - Drop `rst_n` in cycle 2 of a load. Required: `dmem_en` = 0, `stall` = 0 and all outputs = 0 immediately, before the next clock edge.
  - A `dmem_ready` after reset is released is ignored, and the state stays IDLE.
